// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared types and constants for the ALU control sequencer.
package alu_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DECODE    = 2'd1,
      EXECUTE   = 2'd2,
      WRITEBACK = 2'd3
   } state_t;

   // Instruction word field positions
   localparam int OP_HI   = 31;
   localparam int OP_LO   = 26;
   localparam int RD_HI   = 25;
   localparam int RD_LO   = 23;
   localparam int RS1_HI  = 22;
   localparam int RS1_LO  = 20;
   localparam int RS2_HI  = 19;
   localparam int RS2_LO  = 17;
   localparam int IMM_SEL = 16;
   localparam int IMM_HI  = 15;
   localparam int IMM_LO  = 0;
   localparam int IMM_W   = IMM_HI - IMM_LO + 1;

   localparam logic [5:0] OP_NOP = 6'b000000;

   // Bit positions inside the {C,Z,N} flag register
   localparam int FLAG_C = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

endpackage

// File: rtl/alu_ctrl_regfile.sv
// alu_ctrl_regfile: NREGS x DATA_W register file, two async read ports,
// one sync write port, r0 reads as zero and ignores writes.
// With CU_REG_DEBUG_EN defined, a third async read port is added.
module alu_ctrl_regfile #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NREGS  = 8,
   parameter int unsigned AW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [AW-1:0]     ra1,
   output logic [DATA_W-1:0] rd1,
   input  logic [AW-1:0]     ra2,
   output logic [DATA_W-1:0] rd2
`ifdef CU_REG_DEBUG_EN
   ,
   input  logic [AW-1:0]     ra3,
   output logic [DATA_W-1:0] rd3
`endif
);

   logic [DATA_W-1:0] mem [NREGS];

   // Storage: cleared on reset, r0 never written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (we && (wa != '0)) begin
         mem[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
   assign rd2 = (ra2 == '0) ? '0 : mem[ra2];
`ifdef CU_REG_DEBUG_EN
   assign rd3 = (ra3 == '0) ? '0 : mem[ra3];
`endif

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: four-state (IDLE/DECODE/EXECUTE/WRITEBACK) sequencer
// feeding an external combinational ALU and writing results back to an
// internal register file. Optional macro CU_REG_DEBUG_EN adds a
// combinational debug read port (dbg_addr/dbg_data).
module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NREGS  = 8,
   parameter int unsigned OP_W   = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     instr_valid,
   output logic                     instr_ready,
   input  logic [31:0]              instr,
   output logic [DATA_W-1:0]        alu_a,
   output logic [DATA_W-1:0]        alu_b,
   output logic [OP_W-1:0]          alu_op,
   output logic                     alu_cin,
   input  logic [DATA_W-1:0]        alu_result,
   input  logic                     alu_cout,
   input  logic                     alu_z,
   input  logic                     alu_n,
   output logic                     done,
   output logic [$clog2(NREGS)-1:0] wb_rd,
   output logic [DATA_W-1:0]        wb_data,
   output logic [2:0]               flags
`ifdef CU_REG_DEBUG_EN
   ,
   input  logic [$clog2(NREGS)-1:0] dbg_addr,
   output logic [DATA_W-1:0]        dbg_data
`endif
);

   localparam int unsigned AW = $clog2(NREGS);

   state_t            state, state_nxt;
   logic [31:0]       instr_q;
   logic [OP_W-1:0]   op_f;
   logic [AW-1:0]     rd_f, rs1_f, rs2_f;
   logic              use_imm;
   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] rdata1, rdata2, opnd_b;
   logic              c_q, z_q, n_q;
   logic              wr_en;

   assign op_f    = instr_q[OP_HI:OP_LO];
   assign rd_f    = instr_q[RD_HI:RD_LO];
   assign rs1_f   = instr_q[RS1_HI:RS1_LO];
   assign rs2_f   = instr_q[RS2_HI:RS2_LO];
   assign use_imm = instr_q[IMM_SEL];
   assign imm     = instr_q[IMM_HI:IMM_LO];
   assign opnd_b  = use_imm ? {{(DATA_W-IMM_W){1'b0}}, imm} : rdata2;

   // alu_op still holds the current opcode through WRITEBACK, so it doubles
   // as the NOP qualifier for the register/flag commit.
   assign wr_en = (state == WRITEBACK) && (alu_op != OP_NOP);

   alu_ctrl_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .AW     (AW)
   ) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en),
      .wa    (wb_rd),
      .wd    (wb_data),
      .ra1   (rs1_f),
      .rd1   (rdata1),
      .ra2   (rs2_f),
      .rd2   (rdata2)
`ifdef CU_REG_DEBUG_EN
      ,
      .ra3   (dbg_addr),
      .rd3   (dbg_data)
`endif
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake decode
   always_comb begin
      state_nxt   = state;
      instr_ready = 1'b0;
      case (state)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) state_nxt = DECODE;
         end
         DECODE:    state_nxt = EXECUTE;
         EXECUTE:   state_nxt = WRITEBACK;
         WRITEBACK: state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Latch the accepted instruction word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            instr_q <= '0;
      else if (state == IDLE && instr_valid) instr_q <= instr;
   end

   // Register ALU operands at the end of DECODE; they hold until the next DECODE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a   <= '0;
         alu_b   <= '0;
         alu_op  <= '0;
         alu_cin <= 1'b0;
      end else if (state == DECODE) begin
         alu_a   <= rdata1;
         alu_b   <= opnd_b;
         alu_op  <= op_f;
         alu_cin <= flags[FLAG_C];
      end
   end

   // Capture ALU outputs at the end of EXECUTE; done marks the WRITEBACK cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done    <= 1'b0;
         wb_rd   <= '0;
         wb_data <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
      end else begin
         done <= (state == EXECUTE);
         if (state == EXECUTE) begin
            wb_rd   <= rd_f;
            wb_data <= (alu_op == OP_NOP) ? '0 : alu_result;
            c_q     <= alu_cout;
            z_q     <= alu_z;
            n_q     <= alu_n;
         end
      end
   end

   // Architectural flags commit together with the register write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags <= '0;
      end else if (wr_en) begin
         flags[FLAG_C] <= c_q;
         flags[FLAG_Z] <= z_q;
         flags[FLAG_N] <= n_q;
      end
   end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: self-checking bench for alu_ctrl_seq with a behavioural
// ALU and a register/flag reference model.
module tb_alu_ctrl_seq;

   localparam logic [5:0] OP_ADD = 6'b010000;
   localparam logic [5:0] OP_XOR = 6'b000101;
   localparam logic [5:0] NOP    = 6'b000000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] instr = '0;
   logic [31:0] alu_a, alu_b, alu_result, wb_data;
   logic [5:0]  alu_op;
   logic        alu_cin, alu_cout, alu_z, alu_n, done;
   logic [2:0]  wb_rd, flags;
   logic        force_c = 1'b0;
   logic        force_z = 1'b0;
`ifdef CU_REG_DEBUG_EN
   logic [2:0]  dbg_addr = '0;
   logic [31:0] dbg_data;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] ref_regs [8];
   logic [2:0]  ref_flags;

   always #5 clk = ~clk;

   alu_ctrl_seq #(.DATA_W(32), .NREGS(8), .OP_W(6)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_cin     (alu_cin),
      .alu_result  (alu_result),
      .alu_cout    (alu_cout),
      .alu_z       (alu_z),
      .alu_n       (alu_n),
      .done        (done),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .flags       (flags)
`ifdef CU_REG_DEBUG_EN
      ,
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
`endif
   );

   // Behavioural ALU: returns {cout, z, n, result}
   function automatic logic [34:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin,
                                          input logic fc, input logic fz);
      logic [32:0] s;
      if (op == OP_ADD) s = {1'b0, a} + {1'b0, b} + {32'b0, cin};
      else              s = {1'b0, a ^ b};
      return {s[32] | fc, (s[31:0] == 32'd0) | fz, s[31], s[31:0]};
   endfunction

   always_comb {alu_cout, alu_z, alu_n, alu_result} = alu_fn(alu_op, alu_a, alu_b, alu_cin, force_c, force_z);

   task automatic model_reset();
      for (int i = 0; i < 8; i++) ref_regs[i] = '0;
      ref_flags = '0;
   endtask

   // Architectural effect of one instruction
   task automatic model_exec(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic ui, input logic [15:0] imm,
                             input logic fc, input logic fz,
                             output logic [31:0] ea, output logic ecin,
                             output logic [31:0] ewb, output logic [2:0] efl);
      logic [31:0] b;
      logic [34:0] r;
      ea   = (rs1 == 3'd0) ? 32'd0 : ref_regs[rs1];
      b    = ui ? {16'h0, imm} : ((rs2 == 3'd0) ? 32'd0 : ref_regs[rs2]);
      ecin = ref_flags[2];
      r    = alu_fn(op, ea, b, ecin, fc, fz);
      if (op == NOP) begin
         ewb = '0;
      end else begin
         ewb = r[31:0];
         if (rd != 3'd0) ref_regs[rd] = r[31:0];
         ref_flags = r[34:32];
      end
      efl = ref_flags;
   endtask

   // Drive one instruction and observe it. k counts falling edges after the
   // accepting clock edge: k=1 DECODE, k=2 EXECUTE, k=3 WRITEBACK, so done
   // at k=3 is the fourth cycle of the instruction (accepting cycle = first).
   task automatic issue(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic ui, input logic [15:0] imm,
                        input bit junk,
                        output int lat, output int rlow, output int dcnt,
                        output logic [2:0] wrd, output logic [31:0] wdat,
                        output logic [2:0] flg, output logic cin, output logic [31:0] a);
      bit acc;
      acc = 0; lat = -1; rlow = 0; dcnt = 0;
      wrd = '0; wdat = '0; flg = '0; cin = 1'b0; a = '0;
      @(negedge clk);
      instr = {op, rd, rs1, rs2, ui, imm};
      instr_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (instr_ready) begin acc = 1; break; end
         @(negedge clk);
      end
      if (!acc) begin
         instr_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      instr_valid = junk;
      if (junk) instr = $urandom;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (!instr_ready) rlow++;
         if (done) begin
            dcnt++;
            if (lat < 0) begin lat = k; wrd = wb_rd; wdat = wb_data; end
         end
         if (k == 2) begin cin = alu_cin; a = alu_a; end
         if (k == 3) instr_valid = 1'b0;
         if (k == 4) flg = flags;
      end
   endtask

   task automatic test_reset();
      #3;
      n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", instr_ready); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
      n_cmp++; if (flags !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", flags); end
      n_cmp++; if ({alu_a, alu_b, alu_op, alu_cin} !== '0) begin n_bad++; $display("FAIL reset_alu got a=%h b=%h op=%b cin=%b want 0", alu_a, alu_b, alu_op, alu_cin); end
      n_cmp++; if ({wb_rd, wb_data} !== '0) begin n_bad++; $display("FAIL reset_wb got rd=%0d data=%h want 0", wb_rd, wb_data); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_first();
      int lat, rlow, dcnt; logic [2:0] wrd, flg, efl; logic [31:0] wdat, a, ea, ewb; logic cin, ecin;
      model_exec(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd20, 1'b0, 1'b0, ea, ecin, ewb, efl);
      issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd20, 1'b0, lat, rlow, dcnt, wrd, wdat, flg, cin, a);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL first_latency got k=%0d want k=3", lat); end
      n_cmp++; if (rlow !== 3) begin n_bad++; $display("FAIL first_ready_low got %0d want 3", rlow); end
      n_cmp++; if (dcnt !== 1) begin n_bad++; $display("FAIL first_done_width got %0d want 1", dcnt); end
      n_cmp++; if (wrd !== 3'd1) begin n_bad++; $display("FAIL first_wb_rd got %0d want 1", wrd); end
      n_cmp++; if (wdat !== ewb) begin n_bad++; $display("FAIL first_wb_data got %h want %h", wdat, ewb); end
      n_cmp++; if (flg !== efl) begin n_bad++; $display("FAIL first_flags got %b want %b", flg, efl); end
   endtask

   task automatic test_add_regs();
      int lat, rlow, dcnt; logic [2:0] wrd, flg, efl; logic [31:0] wdat, a, ea, ewb; logic cin, ecin;
      model_exec(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'd9, 1'b0, 1'b0, ea, ecin, ewb, efl);
      issue(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'd9, 1'b0, lat, rlow, dcnt, wrd, wdat, flg, cin, a);
      model_exec(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, 1'b0, 1'b0, ea, ecin, ewb, efl);
      issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, 1'b0, lat, rlow, dcnt, wrd, wdat, flg, cin, a);
      n_cmp++; if (wdat !== ewb) begin n_bad++; $display("FAIL add_regs_data got %h want %h", wdat, ewb); end
      n_cmp++; if (cin !== ecin) begin n_bad++; $display("FAIL add_regs_cin got %b want %b", cin, ecin); end
      n_cmp++; if (a !== ea) begin n_bad++; $display("FAIL add_regs_a got %h want %h", a, ea); end
   endtask

   task automatic test_flags_nop();
      int lat, rlow, dcnt; logic [2:0] wrd, flg, efl; logic [31:0] wdat, a, ea, ewb; logic cin, ecin;
      model_exec(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF, 1'b0, 1'b0, ea, ecin, ewb, efl);
      issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF, 1'b0, lat, rlow, dcnt, wrd, wdat, flg, cin, a);
      force_c = 1'b1; force_z = 1'b1;
      model_exec(OP_ADD, 3'd4, 3'd4, 3'd0, 1'b1, 16'd0, 1'b1, 1'b1, ea, ecin, ewb, efl);
      issue(OP_ADD, 3'd4, 3'd4, 3'd0, 1'b1, 16'd0, 1'b0, lat, rlow, dcnt, wrd, wdat, flg, cin, a);
      force_c = 1'b0; force_z = 1'b0;
      n_cmp++; if (flg !== efl) begin n_bad++; $display("FAIL forced_flags got %b want %b", flg, efl); end
      // NOP: walks all states, carries C=1 into alu_cin, commits nothing
      model_exec(NOP, 3'd5, 3'd1, 3'd0, 1'b1, 16'h1234, 1'b0, 1'b0, ea, ecin, ewb, efl);
      issue(NOP, 3'd5, 3'd1, 3'd0, 1'b1, 16'h1234, 1'b0, lat, rlow, dcnt, wrd, wdat, flg, cin, a);
      n_cmp++; if (cin !== ecin) begin n_bad++; $display("FAIL nop_cin got %b want %b", cin, ecin); end
      n_cmp++; if (lat !== 3 || dcnt !== 1) begin n_bad++; $display("FAIL nop_done got k=%0d count=%0d want k=3 count=1", lat, dcnt); end
      n_cmp++; if (wdat !== ewb) begin n_bad++; $display("FAIL nop_wb_data got %h want %h", wdat, ewb); end
      n_cmp++; if (flg !== efl) begin n_bad++; $display("FAIL nop_flags got %b want %b", flg, efl); end
`ifdef CU_REG_DEBUG_EN
      dbg_addr = 3'd5; #1;
      n_cmp++; if (dbg_data !== ref_regs[5]) begin n_bad++; $display("FAIL nop_dbg_r5 got %h want %h", dbg_data, ref_regs[5]); end
`endif
      model_exec(OP_ADD, 3'd6, 3'd5, 3'd0, 1'b1, 16'd0, 1'b0, 1'b0, ea, ecin, ewb, efl);
      issue(OP_ADD, 3'd6, 3'd5, 3'd0, 1'b1, 16'd0, 1'b0, lat, rlow, dcnt, wrd, wdat, flg, cin, a);
      n_cmp++; if (a !== ea) begin n_bad++; $display("FAIL nop_r5_read got %h want %h", a, ea); end
      n_cmp++; if (wdat !== ewb) begin n_bad++; $display("FAIL nop_followup_data got %h want %h", wdat, ewb); end
   endtask

   task automatic test_r0();
      int lat, rlow, dcnt; logic [2:0] wrd, flg, efl; logic [31:0] wdat, a, ea, ewb; logic cin, ecin;
      model_exec(OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 16'd7, 1'b0, 1'b0, ea, ecin, ewb, efl);
      issue(OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 16'd7, 1'b0, lat, rlow, dcnt, wrd, wdat, flg, cin, a);
      n_cmp++; if (lat !== 3 || wrd !== 3'd0) begin n_bad++; $display("FAIL r0_done got k=%0d rd=%0d want k=3 rd=0", lat, wrd); end
      n_cmp++; if (wdat !== ewb) begin n_bad++; $display("FAIL r0_wb_data got %h want %h", wdat, ewb); end
      model_exec(OP_ADD, 3'd7, 3'd0, 3'd2, 1'b0, 16'd0, 1'b0, 1'b0, ea, ecin, ewb, efl);
      issue(OP_ADD, 3'd7, 3'd0, 3'd2, 1'b0, 16'd0, 1'b0, lat, rlow, dcnt, wrd, wdat, flg, cin, a);
      n_cmp++; if (a !== ea) begin n_bad++; $display("FAIL r0_read got %h want %h", a, ea); end
   endtask

   task automatic test_back_to_back();
      int lat, rlow, dcnt; logic [2:0] wrd, flg, efl; logic [31:0] wdat, a, ea, ewb; logic cin, ecin;
      logic [5:0] op; logic [2:0] rd, rs1, rs2; logic ui; logic [15:0] imm; int sel;
      for (int t = 0; t < 30; t++) begin
         sel = $urandom_range(0, 3);
         op  = (sel == 0) ? NOP : ((sel == 3) ? OP_XOR : OP_ADD);
         rd  = 3'($urandom_range(0, 7));
         rs1 = 3'($urandom_range(0, 7));
         rs2 = 3'($urandom_range(0, 7));
         ui  = 1'($urandom_range(0, 1));
         imm = 16'($urandom);
         model_exec(op, rd, rs1, rs2, ui, imm, 1'b0, 1'b0, ea, ecin, ewb, efl);
         issue(op, rd, rs1, rs2, ui, imm, 1'($urandom_range(0, 1)), lat, rlow, dcnt, wrd, wdat, flg, cin, a);
         n_cmp++;
         if (lat !== 3 || dcnt !== 1 || rlow !== 3 || wrd !== rd || wdat !== ewb || flg !== efl || cin !== ecin || a !== ea) begin
            n_bad++;
            $display("FAIL rand_%0d got k=%0d n=%0d rl=%0d rd=%0d d=%h f=%b cin=%b a=%h want k=3 n=1 rl=3 rd=%0d d=%h f=%b cin=%b a=%h",
                     t, lat, dcnt, rlow, wrd, wdat, flg, cin, a, rd, ewb, efl, ecin, ea);
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat, rlow, dcnt; logic [2:0] wrd, flg, efl; logic [31:0] wdat, a, ea, ewb; logic cin, ecin;
      int dseen;
      model_exec(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd55, 1'b1, 1'b1, ea, ecin, ewb, efl);
      issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd55, 1'b0, lat, rlow, dcnt, wrd, wdat, flg, cin, a);
      dseen = 0;
      @(negedge clk);
      instr = {OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 16'd3};
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++; if (flags !== 3'b000) begin n_bad++; $display("FAIL midrst_flags_async got %b want 000", flags); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) dseen++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) dseen++;
      end
      n_cmp++; if (dseen !== 0) begin n_bad++; $display("FAIL midrst_done got %0d pulses want 0", dseen); end
      n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", instr_ready); end
      n_cmp++; if (flags !== ref_flags) begin n_bad++; $display("FAIL midrst_flags got %b want %b", flags, ref_flags); end
`ifdef CU_REG_DEBUG_EN
      for (int r = 0; r < 8; r++) begin
         dbg_addr = 3'(r); #1;
         n_cmp++; if (dbg_data !== ref_regs[r]) begin n_bad++; $display("FAIL midrst_dbg_r%0d got %h want %h", r, dbg_data, ref_regs[r]); end
      end
`endif
      model_exec(OP_ADD, 3'd3, 3'd1, 3'd0, 1'b1, 16'd0, 1'b0, 1'b0, ea, ecin, ewb, efl);
      issue(OP_ADD, 3'd3, 3'd1, 3'd0, 1'b1, 16'd0, 1'b0, lat, rlow, dcnt, wrd, wdat, flg, cin, a);
      n_cmp++; if (a !== ea) begin n_bad++; $display("FAIL midrst_r1_cleared got %h want %h", a, ea); end
      n_cmp++; if (cin !== ecin) begin n_bad++; $display("FAIL midrst_cin got %b want %b", cin, ecin); end
   endtask

   initial begin
      test_reset();
      test_first();
      test_add_regs();
      test_flags_nop();
      test_r0();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Guard against a stalled run
   initial begin
      #200000;
      $display("FAIL timeout got no completion want summary");
      $fatal(1, "timeout");
   end

endmodule
